valu_seq: RTL and testbench

- Parametrised, sequential successor to the combinational vector ALU.
- Accepts a full operand vector through a valid/ready handshake and processes LANES elements per cycle over ELEMENTS/LANES beats.
- Supports per-element masking and an extended op set, and holds the result vector until the consumer accepts it.
- Sits between the vector register-file read stage and the writeback stage.

---
 rtl/valu_pkg.sv | 35 +++
 rtl/valu_lane.sv | 44 ++++
 rtl/valu_seq.sv | 160 ++++++++++++++++
 tb/tb_valu_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/valu_pkg.sv
// Shared types for the sequential vector ALU: opcode and FSM state enums,
// plus the shift-amount width helper.
package valu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SRA  = 4'h7,
    OP_MINU = 4'h8,
    OP_MAXU = 4'h9,
    OP_MIN  = 4'hA,
    OP_MAX  = 4'hB,
    OP_SEQ  = 4'hC,
    OP_SLTU = 4'hD,
    OP_SLT  = 4'hE,
    OP_ILL  = 4'hF
  } valu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } valu_state_e;

  // Bits of operand A used as the shift amount for a given element width.
  function automatic int shamt_w(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/valu_lane.sv
// Combinational single-element ALU. One instance per lane; the sequencer
// feeds it a different element pair every beat.
module valu_lane
  import valu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  valu_op_e              op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  illegal_o
);

  localparam int SHAMT_W = shamt_w(DATA_WIDTH);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = a_i[SHAMT_W-1:0];

  // Element result; an unsupported op yields zero and flags illegal.
  always_comb begin
    res_o     = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_SLL:  res_o = b_i << shamt;
      OP_SRL:  res_o = b_i >> shamt;
      OP_SRA:  res_o = DATA_WIDTH'($signed(b_i) >>> shamt);
      OP_MINU: res_o = (a_i < b_i) ? a_i : b_i;
      OP_MAXU: res_o = (a_i < b_i) ? b_i : a_i;
      OP_MIN:  res_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
      OP_MAX:  res_o = ($signed(a_i) < $signed(b_i)) ? b_i : a_i;
      OP_SEQ:  res_o = DATA_WIDTH'(a_i == b_i);
      OP_SLTU: res_o = DATA_WIDTH'(a_i < b_i);
      OP_SLT:  res_o = DATA_WIDTH'($signed(a_i) < $signed(b_i));
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/valu_seq.sv
// Sequential vector ALU. Accepts a whole operand vector, computes LANES
// elements per beat over ELEMENTS/LANES beats, then holds the result.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits for ready, and once the result valid is
// raised it stays high with stable data until the consumer takes it.
module valu_seq
  import valu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMENTS   = 8,
  parameter int LANES      = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  in_valid_in,
  output logic                  in_ready_o,
  input  logic [3:0]            valu_op_in,
  input  logic [DATA_WIDTH-1:0] vrs1_data_in [ELEMENTS],
  input  logic [DATA_WIDTH-1:0] vrs2_data_in [ELEMENTS],
  input  logic [DATA_WIDTH-1:0] vd_old_in    [ELEMENTS],
  input  logic [ELEMENTS-1:0]   vmask_in,
  output logic                  out_valid_o,
  input  logic                  out_ready_in,
  output logic [DATA_WIDTH-1:0] valu_res_o   [ELEMENTS],
  output logic                  illegal_op_o,
  output valu_state_e           state_o
);

  localparam int BEATS = ELEMENTS / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (ELEMENTS % LANES != 0) begin : g_lanes_check
    $error("valu_seq: ELEMENTS must be a multiple of LANES");
  end

  valu_state_e           state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  valu_op_e              op_q;
  logic [DATA_WIDTH-1:0] a_q   [ELEMENTS];
  logic [DATA_WIDTH-1:0] b_q   [ELEMENTS];
  logic [DATA_WIDTH-1:0] old_q [ELEMENTS];
  logic [ELEMENTS-1:0]   mask_q;
  logic [DATA_WIDTH-1:0] res_q [ELEMENTS];
  logic [DATA_WIDTH-1:0] res_d [ELEMENTS];
  logic                  illegal_q, illegal_d;

  logic [DATA_WIDTH-1:0] lane_a   [LANES];
  logic [DATA_WIDTH-1:0] lane_b   [LANES];
  logic [DATA_WIDTH-1:0] lane_res [LANES];
  logic [LANES-1:0]      lane_ill;

  logic accept;
  logic last_beat;

  assign accept    = in_valid_in && in_ready_o;
  assign last_beat = (beat_q == BW'(BEATS - 1));

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; DONE->IDLE never overlaps with a new accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)       state_d = EXEC;
      EXEC:    if (last_beat)    state_d = DONE;
      DONE:    if (out_ready_in) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state only
  always_comb begin
    in_ready_o   = (state_q == IDLE);
    out_valid_o  = (state_q == DONE);
    illegal_op_o = (state_q == DONE) && illegal_q;
    state_o      = state_q;
  end

  // Beat counter: cleared on accept, advances each EXEC cycle
  always_comb begin
    beat_d = beat_q;
    if (accept)                 beat_d = '0;
    else if (state_q == EXEC)   beat_d = last_beat ? '0 : beat_q + BW'(1);
  end

  // Route the current beat's element pair to each lane
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_a[l] = '0;
      lane_b[l] = '0;
      for (int bt = 0; bt < BEATS; bt++) begin
        if (beat_q == BW'(bt)) begin
          lane_a[l] = a_q[bt*LANES + l];
          lane_b[l] = b_q[bt*LANES + l];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    valu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .op_i     (op_q),
      .a_i      (lane_a[g]),
      .b_i      (lane_b[g]),
      .res_o    (lane_res[g]),
      .illegal_o(lane_ill[g])
    );
  end

  // Result update: illegal forces zero, mask-off keeps the old destination
  always_comb begin
    res_d     = res_q;
    illegal_d = illegal_q;
    if (accept) illegal_d = 1'b0;
    if (state_q == EXEC) begin
      illegal_d = illegal_q | (|lane_ill);
      for (int e = 0; e < ELEMENTS; e++) begin
        if (beat_q == BW'(e / LANES)) begin
          if (lane_ill[e % LANES]) res_d[e] = '0;
          else if (mask_q[e])      res_d[e] = lane_res[e % LANES];
          else                     res_d[e] = old_q[e];
        end
      end
    end
  end

  // Datapath registers: operands captured only at the accept edge
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      beat_q    <= '0;
      illegal_q <= 1'b0;
      op_q      <= OP_ADD;
      mask_q    <= '0;
      for (int e = 0; e < ELEMENTS; e++) begin
        res_q[e] <= '0;
        a_q[e]   <= '0;
        b_q[e]   <= '0;
        old_q[e] <= '0;
      end
    end else begin
      beat_q    <= beat_d;
      illegal_q <= illegal_d;
      res_q     <= res_d;
      if (accept) begin
        op_q   <= valu_op_e'(valu_op_in);
        mask_q <= vmask_in;
        a_q    <= vrs1_data_in;
        b_q    <= vrs2_data_in;
        old_q  <= vd_old_in;
      end
    end
  end

  assign valu_res_o = res_q;

endmodule

// File: tb/tb_valu_seq.sv
// Bench for valu_seq: three instances (LANES = 2, 1, 8) share operand
// inputs; each has its own valid/ready. Results are compared against an
// arithmetic reference model through an expected-value queue.
module tb_valu_seq;
  import valu_pkg::*;

  localparam int DW = 32;
  localparam int NE = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic          illegal   [3];
  valu_state_e   dbg_state [3];
  logic [3:0]    op_in;
  logic [DW-1:0] a_in   [NE];
  logic [DW-1:0] b_in   [NE];
  logic [DW-1:0] old_in [NE];
  logic [NE-1:0] mask_in;
  logic [DW-1:0] res0 [NE];
  logic [DW-1:0] res1 [NE];
  logic [DW-1:0] res2 [NE];

  int beats [3] = '{4, 8, 1};

  valu_seq #(.DATA_WIDTH(DW), .ELEMENTS(NE), .LANES(2)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .in_valid_in(in_valid[0]), .in_ready_o(in_ready[0]),
    .valu_op_in(op_in), .vrs1_data_in(a_in), .vrs2_data_in(b_in), .vd_old_in(old_in),
    .vmask_in(mask_in), .out_valid_o(out_valid[0]), .out_ready_in(out_ready[0]),
    .valu_res_o(res0), .illegal_op_o(illegal[0]), .state_o(dbg_state[0]));

  valu_seq #(.DATA_WIDTH(DW), .ELEMENTS(NE), .LANES(1)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .in_valid_in(in_valid[1]), .in_ready_o(in_ready[1]),
    .valu_op_in(op_in), .vrs1_data_in(a_in), .vrs2_data_in(b_in), .vd_old_in(old_in),
    .vmask_in(mask_in), .out_valid_o(out_valid[1]), .out_ready_in(out_ready[1]),
    .valu_res_o(res1), .illegal_op_o(illegal[1]), .state_o(dbg_state[1]));

  valu_seq #(.DATA_WIDTH(DW), .ELEMENTS(NE), .LANES(8)) u_dut2 (
    .clk_in(clk), .rst_in(rst), .in_valid_in(in_valid[2]), .in_ready_o(in_ready[2]),
    .valu_op_in(op_in), .vrs1_data_in(a_in), .vrs2_data_in(b_in), .vd_old_in(old_in),
    .vmask_in(mask_in), .out_valid_o(out_valid[2]), .out_ready_in(out_ready[2]),
    .valu_res_o(res2), .illegal_op_o(illegal[2]), .state_o(dbg_state[2]));

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] get_res(input int k, input int e);
    case (k)
      0:       return res0[e];
      1:       return res1[e];
      default: return res2[e];
    endcase
  endfunction

  // Reference model of one element
  function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] old,
                                          input logic m);
    longint unsigned ua, ub;
    int sa, sb, sh;
    ua = a; ub = b; sa = a; sb = b; sh = int'(a % 32);
    if (op == 4'hF) return '0;
    if (!m) return old;
    case (op)
      4'h0: return DW'(ua + ub);
      4'h1: return DW'(ua - ub);
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return b << sh;
      4'h6: return b >> sh;
      4'h7: return DW'(sb >>> sh);
      4'h8: return (ua < ub) ? a : b;
      4'h9: return (ua < ub) ? b : a;
      4'hA: return (sa < sb) ? a : b;
      4'hB: return (sa < sb) ? b : a;
      4'hC: return (a == b) ? 1 : 0;
      4'hD: return (ua < ub) ? 1 : 0;
      default: return (sa < sb) ? 1 : 0;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [3:0]    st_op;
  logic [DW-1:0] st_a   [NE];
  logic [DW-1:0] st_b   [NE];
  logic [DW-1:0] st_old [NE];
  logic [NE-1:0] st_m;

  function automatic logic [DW-1:0] rand_word();
    if ($urandom_range(0, 3) == 0) return DW'($urandom_range(0, 3));
    return $urandom();
  endfunction

  task automatic scramble_inputs();
    op_in   = 4'($urandom());
    mask_in = 8'($urandom());
    for (int e = 0; e < NE; e++) begin
      a_in[e] = $urandom(); b_in[e] = $urandom(); old_in[e] = $urandom();
    end
  endtask

  task automatic drive_accept(input int k);
    int guard;
    guard = 0;
    while (!in_ready[k] && guard < 64) begin @(posedge clk); #1; guard++; end
    check_eq("in_ready_idle", 32'(in_ready[k]), 32'd1);
    op_in = st_op; mask_in = st_m;
    a_in = st_a; b_in = st_b; old_in = st_old;
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    scramble_inputs();
  endtask

  // Push one vector through DUT k, hold the result for 'hold' cycles, then take it
  task automatic run_vec(input int k, input int hold);
    logic [DW-1:0] exp_cur [NE];
    logic          exp_ill;
    int lat;
    for (int e = 0; e < NE; e++) exp_q.push_back(model(st_op, st_a[e], st_b[e], st_old[e], st_m[e]));
    exp_ill = (st_op == 4'hF);
    for (int e = 0; e < NE; e++) exp_cur[e] = exp_q.pop_front();
    drive_accept(k);
    lat = 0;
    while (!out_valid[k] && lat < 64) begin @(posedge clk); #1; lat++; end
    check_eq($sformatf("latency_dut%0d", k), 32'(lat), 32'(beats[k]));
    for (int e = 0; e < NE; e++)
      check_eq($sformatf("res_dut%0d_op%0h[%0d]", k, st_op, e), get_res(k, e), exp_cur[e]);
    check_eq("illegal", 32'(illegal[k]), 32'(exp_ill));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(out_valid[k]), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready[k]), 32'd0);
      for (int e = 0; e < NE; e++)
        check_eq($sformatf("hold_res[%0d]", e), get_res(k, e), exp_cur[e]);
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check_eq("post_take_valid", 32'(out_valid[k]), 32'd0);
    check_eq("post_take_in_ready", 32'(in_ready[k]), 32'd1);
  endtask

  // Reset one cycle after accept (2nd EXEC beat, or DONE when one beat)
  task automatic reset_abort(input int k);
    drive_accept(k);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_abort_valid", 32'(out_valid[k]), 32'd0);
    check_eq("rst_abort_in_ready", 32'(in_ready[k]), 32'd1);
    for (int e = 0; e < NE; e++)
      check_eq($sformatf("rst_abort_res[%0d]", e), get_res(k, e), 32'd0);
  endtask

  task automatic set_vec(input logic [3:0] op, input logic [NE-1:0] m);
    st_op = op; st_m = m;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin in_valid[k] = 1'b0; out_ready[k] = 1'b0; end
    scramble_inputs();
    for (int e = 0; e < NE; e++) begin st_a[e] = '0; st_b[e] = '0; st_old[e] = '0; end
    st_op = 4'h0; st_m = '1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("reset_in_ready", 32'(in_ready[k]), 32'd1);
      check_eq("reset_out_valid", 32'(out_valid[k]), 32'd0);
      check_eq("reset_illegal", 32'(illegal[k]), 32'd0);
      check_eq("reset_state", 32'(dbg_state[k]), 32'(IDLE));
      for (int e = 0; e < NE; e++) check_eq("reset_res", get_res(k, e), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD 1..8 + 1..8
    for (int e = 0; e < NE; e++) begin st_a[e] = e + 1; st_b[e] = e + 1; end
    set_vec(4'h0, 8'hFF); run_vec(0, 0);
    // SUB wrap
    for (int e = 0; e < NE; e++) begin st_a[e] = 0; st_b[e] = 1; end
    set_vec(4'h1, 8'hFF); run_vec(0, 0);
    // SRA by 31
    for (int e = 0; e < NE; e++) begin st_a[e] = 31; st_b[e] = 32'h8000_0000; end
    set_vec(4'h7, 8'hFF); run_vec(0, 0);
    // masked ADD
    for (int e = 0; e < NE; e++) begin st_a[e] = 10 * e; st_b[e] = e; st_old[e] = 32'hDEAD_BEEF; end
    set_vec(4'h0, 8'b1010_1010); run_vec(0, 0);
    // backpressure with 5 held cycles
    for (int e = 0; e < NE; e++) begin st_a[e] = rand_word(); st_b[e] = rand_word(); end
    set_vec(4'h4, 8'hFF); run_vec(0, 5);
    // illegal op (mask partly off: illegal still forces zero)
    set_vec(4'hF, 8'h0F); run_vec(0, 1);
    // MIN / MINU on 0xFFFFFFFF vs 1
    for (int e = 0; e < NE; e++) begin st_a[e] = 32'hFFFF_FFFF; st_b[e] = 1; end
    set_vec(4'hA, 8'hFF); run_vec(0, 0);
    set_vec(4'h8, 8'hFF); run_vec(0, 0);

    // reset abort on each lane count, then a clean vector
    for (int k = 0; k < 3; k++) begin
      for (int e = 0; e < NE; e++) begin st_a[e] = e + 3; st_b[e] = 7; st_old[e] = 32'h1234_5678; end
      set_vec(4'h0, 8'hFF); run_vec(k, 0);
      reset_abort(k);
      for (int e = 0; e < NE; e++) begin st_a[e] = rand_word(); st_b[e] = rand_word(); end
      set_vec(4'h1, 8'h5A); run_vec(k, 0);
    end

    // randomized vectors across all instances and ops
    for (int i = 0; i < 30; i++) begin
      for (int e = 0; e < NE; e++) begin
        st_a[e] = rand_word(); st_b[e] = rand_word(); st_old[e] = $urandom();
      end
      set_vec(4'($urandom_range(0, 15)), 8'($urandom()));
      run_vec(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
